// File: rtl/countdown_ctrl.sv
// countdown_ctrl: sequencer for an N-bit down-counter.
// Loads a start value, decrements on qualified ticks, supports pause and abort,
// and reports terminal count with a one-cycle done pulse.
// Optional build macro COUNTDOWN_AUTORELOAD_EN: on terminal count the counter
// reloads the captured start value and keeps running instead of entering DONE.
module countdown_ctrl #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] load_value,
    input  logic         tick,
    input  logic         pause,
    input  logic         abort,
    output logic [N-1:0] count,
    output logic         busy,
    output logic         done,
    output logic [1:0]   state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] count_q, count_d;

    // Terminal-count qualifier: a tick in RUN that is not overridden by abort/pause
    // while the counter sits at 1.
    logic         term_hit;

`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [N-1:0] reload_q, reload_d;
    logic         done_q, done_d;
`endif

    // Decrement that saturates at zero; 0 is terminal and never wraps to all-ones.
    function automatic logic [N-1:0] dec_sat(input logic [N-1:0] v);
        return (v == '0) ? '0 : v - N'(1);
    endfunction

    assign term_hit = (state_q == S_RUN) && !abort && !pause && tick
                      && (count_q == N'(1));

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision; priority in RUN and PAUSE is abort > pause > tick.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (load_value != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (pause) begin
                    state_d = S_PAUSE;
                end else if (term_hit) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
                    state_d = S_RUN;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_PAUSE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!pause) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counter (and reload) next value, following the same priorities as the FSM.
    always_comb begin
        count_d = count_q;
`ifdef COUNTDOWN_AUTORELOAD_EN
        reload_d = reload_q;
        done_d   = term_hit;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d = load_value;
`ifdef COUNTDOWN_AUTORELOAD_EN
                    if (load_value != '0) begin
                        reload_d = load_value;
                    end
`endif
                end
            end
            S_RUN: begin
                if (abort) begin
                    count_d = '0;
                end else if (pause) begin
                    count_d = count_q;
                end else if (term_hit) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
                    count_d = reload_q;
`else
                    count_d = '0;
`endif
                end else if (tick) begin
                    count_d = dec_sat(count_q);
                end
            end
            S_PAUSE: begin
                if (abort) begin
                    count_d = '0;
                end
            end
            S_DONE: begin
                count_d = '0;
            end
            default: count_d = '0;
        endcase
    end

    // Datapath registers; reset clears the count (and reload/pulse when present).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
`ifdef COUNTDOWN_AUTORELOAD_EN
            reload_q <= '0;
            done_q   <= 1'b0;
`endif
        end else begin
            count_q <= count_d;
`ifdef COUNTDOWN_AUTORELOAD_EN
            reload_q <= reload_d;
            done_q   <= done_d;
`endif
        end
    end

    // Moore outputs decoded from registered state only.
    always_comb begin
        count   = count_q;
        state_o = state_q;
        busy    = (state_q == S_RUN) || (state_q == S_PAUSE);
`ifdef COUNTDOWN_AUTORELOAD_EN
        done    = (state_q == S_DONE) || done_q;
`else
        done    = (state_q == S_DONE);
`endif
    end

endmodule
